spi_master_ctrl: RTL and testbench

SPI master that drives the RAM-backed SPI slave from the host side. It accepts a 2-bit command and 8-bit payload over a start/done handshake and serialises the 10-bit frame onto MOSI, MSB first. For read-data commands it also shifts 8 bits back in from MISO. It generates SCLK, SS_n and MOSI, so the slave's `clk` is this block's `sclk`.

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_sclk_gen.sv | 53 +++++
 rtl/spi_master_ctrl.sv | 171 +++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: command encodings, frame sizes and
// the master FSM state encoding.
package spi_pkg;

   localparam int FRAME_W = 10;
   localparam int DATA_W  = 8;
   localparam int CNT_W   = 4;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_TURN  = 3'd3,
      ST_RECV  = 3'd4,
      ST_GAP   = 3'd5
   } state_e;

   function automatic logic is_rd_data(input logic [1:0] cmd);
      return cmd == CMD_RD_DATA;
   endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: each SCLK period is a low half then a high half of CLK_DIV
// clk cycles; ticks flag the clk cycle in which SCLK is about to toggle.
module spi_sclk_gen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic sclk,
   output logic rise_tick,
   output logic fall_tick
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             sclk_q, sclk_d;
   logic             wrap;

   assign wrap = enable && (div_q == DIV_LAST);

   always_comb begin
      div_d  = div_q;
      sclk_d = sclk_q;
      if (!enable) begin
         div_d  = '0;
         sclk_d = 1'b0;
      end else if (wrap) begin
         div_d  = '0;
         sclk_d = ~sclk_q;
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk      = sclk_q;
   assign rise_tick = wrap && !sclk_q;
   assign fall_tick = wrap && sclk_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master (mode 0): sends a 10-bit {cmd, din} frame MSB first and, for
// read-data commands, shifts a byte back in from MISO after a turnaround.
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int TURN    = 2,
   parameter int GAP     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        cmd,
   input  logic [DATA_W-1:0] din,
   output logic              ready,
   output logic              done,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              sclk,
   output logic              ss_n,
   output logic              mosi,
   input  logic              miso,
   output state_e            dbg_state_o
);

   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'((TURN > 0) ? TURN - 1 : 0);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP > 0) ? GAP - 1 : 0);

   state_e              state_q, state_d;
   logic [FRAME_W-1:0]  frame_q, frame_d;
   logic [DATA_W-1:0]   rx_q, rx_d;
   logic [DATA_W-1:0]   dout_q, dout_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                rd_q, rd_d;
   logic                done_q, done_d;
   logic                dv_q, dv_d;
   logic                finish;

   logic gen_sclk, rise_tick, fall_tick, gen_en;

   assign gen_en = (state_q != ST_IDLE);

   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clk       (clk),
      .rst       (rst),
      .enable    (gen_en),
      .sclk      (gen_sclk),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick)
   );

   // Valid/ready: a request is taken on any clk edge where start && ready;
   // ready stays low through the done cycle so a held start re-fires one
   // cycle after done.
   assign ready = (state_q == ST_IDLE) && !done_q;

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      rx_d    = rx_q;
      dout_d  = dout_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      done_d  = 1'b0;
      dv_d    = 1'b0;
      finish  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && ready) begin
               frame_d = {cmd, din};
               rd_d    = is_rd_data(cmd);
               cnt_d   = '0;
               state_d = ST_LEAD;
            end
         end
         ST_LEAD: begin
            if (fall_tick) begin
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (fall_tick) begin
               if (cnt_q == SHIFT_LAST) begin
                  cnt_d = '0;
                  if (rd_q)         state_d = (TURN > 0) ? ST_TURN : ST_RECV;
                  else if (GAP > 0) state_d = ST_GAP;
                  else              finish  = 1'b1;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  frame_d = {frame_q[FRAME_W-2:0], 1'b0};
               end
            end
         end
         ST_TURN: begin
            if (fall_tick) begin
               if (cnt_q == TURN_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_RECV;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_RECV: begin
            if (rise_tick) rx_d = {rx_q[DATA_W-2:0], miso};
            if (fall_tick) begin
               if (cnt_q == RECV_LAST) begin
                  cnt_d = '0;
                  if (GAP > 0) state_d = ST_GAP;
                  else         finish  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_GAP: begin
            if (fall_tick) begin
               if (cnt_q == GAP_LAST) finish = 1'b1;
               else                   cnt_d  = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (finish) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         done_d  = 1'b1;
         if (rd_q) begin
            dout_d = rx_q;
            dv_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         frame_q <= '0;
         rx_q    <= '0;
         dout_q  <= '0;
         cnt_q   <= '0;
         rd_q    <= 1'b0;
         done_q  <= 1'b0;
         dv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         rx_q    <= rx_d;
         dout_q  <= dout_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         done_q  <= done_d;
         dv_q    <= dv_d;
      end
   end

   // The divider keeps running through GAP to time it, but SCLK is held low.
   assign sclk        = gen_sclk && (state_q != ST_GAP);
   assign ss_n        = !(state_q inside {ST_LEAD, ST_SHIFT, ST_TURN, ST_RECV});
   assign mosi        = (state_q inside {ST_LEAD, ST_SHIFT}) ? frame_q[FRAME_W-1] : 1'b0;
   assign done        = done_q;
   assign dout_valid  = dv_q;
   assign dout        = dout_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl at CLK_DIV = 2, 1 and 5, with a
// cycle-sampled slave model that records MOSI and drives MISO.
module tb_spi_master_ctrl;
   import spi_pkg::*;

   localparam int N = 3;

   logic       clk, rst;
   logic       start_a [N];
   logic [1:0] cmd_a [N];
   logic [7:0] din_a [N];
   logic       miso_a [N];
   logic       ready_a [N], done_a [N], dout_valid_a [N];
   logic       sclk_a [N], ss_n_a [N], mosi_a [N];
   logic [7:0] dout_a [N];
   state_e     st_a [N];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [7:0] exp_q [$];
   logic [7:0] exp_dout [N];

   int         mon_rises, mon_falls, mon_frames, mon_low, mon_hi, mon_last_hi;
   int         mon_done, mon_dv, mon_sclk_bad, mon_fall_cyc, mon_done_cyc;
   logic       mon_ready_at_done, mon_prev_sclk, mon_prev_ss;
   logic [9:0] mon_bits;
   logic [7:0] mon_rx;

   spi_master_ctrl #(.CLK_DIV(2), .TURN(2), .GAP(2)) u_dut0 (
      .clk(clk), .rst(rst), .start(start_a[0]), .cmd(cmd_a[0]), .din(din_a[0]),
      .ready(ready_a[0]), .done(done_a[0]), .dout(dout_a[0]), .dout_valid(dout_valid_a[0]),
      .sclk(sclk_a[0]), .ss_n(ss_n_a[0]), .mosi(mosi_a[0]), .miso(miso_a[0]),
      .dbg_state_o(st_a[0]));

   spi_master_ctrl #(.CLK_DIV(1), .TURN(2), .GAP(2)) u_dut1 (
      .clk(clk), .rst(rst), .start(start_a[1]), .cmd(cmd_a[1]), .din(din_a[1]),
      .ready(ready_a[1]), .done(done_a[1]), .dout(dout_a[1]), .dout_valid(dout_valid_a[1]),
      .sclk(sclk_a[1]), .ss_n(ss_n_a[1]), .mosi(mosi_a[1]), .miso(miso_a[1]),
      .dbg_state_o(st_a[1]));

   spi_master_ctrl #(.CLK_DIV(5), .TURN(2), .GAP(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start_a[2]), .cmd(cmd_a[2]), .din(din_a[2]),
      .ready(ready_a[2]), .done(done_a[2]), .dout(dout_a[2]), .dout_valid(dout_valid_a[2]),
      .sclk(sclk_a[2]), .ss_n(ss_n_a[2]), .mosi(mosi_a[2]), .miso(miso_a[2]),
      .dbg_state_o(st_a[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int div_of(input int k);
      case (k)
         0:       return 2;
         1:       return 1;
         default: return 5;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
   endtask

   task automatic mon_clear(input logic [7:0] rx);
      mon_rx        = rx;
      mon_rises     = 0;
      mon_falls     = 0;
      mon_frames    = 0;
      mon_low       = 0;
      mon_hi        = 0;
      mon_last_hi   = 0;
      mon_done      = 0;
      mon_dv        = 0;
      mon_sclk_bad  = 0;
      mon_fall_cyc  = 0;
      mon_done_cyc  = 0;
      mon_bits      = '0;
      mon_prev_sclk = 1'b0;
      mon_prev_ss   = 1'b1;
      mon_ready_at_done = 1'b0;
   endtask

   // One negedge sample of instance k: slave behaviour plus bookkeeping.
   task automatic mon_step(input int k);
      @(negedge clk);
      cyc++;
      if (!ss_n_a[k] && mon_prev_ss) begin
         mon_frames++;
         mon_last_hi  = mon_hi;
         mon_hi       = 0;
         mon_low      = 0;
         mon_rises    = 0;
         mon_falls    = 0;
         mon_fall_cyc = cyc;
      end
      if (!ss_n_a[k]) mon_low++;
      else begin
         mon_hi++;
         if (sclk_a[k]) mon_sclk_bad++;
      end
      if (!mon_prev_sclk && sclk_a[k]) begin
         mon_rises++;
         if (mon_rises >= 2 && mon_rises <= 11) mon_bits[11-mon_rises] = mosi_a[k];
      end
      if (mon_prev_sclk && !sclk_a[k]) begin
         mon_falls++;
         if (mon_falls >= 13 && mon_falls <= 20) miso_a[k] = mon_rx[20-mon_falls];
      end
      if (done_a[k]) begin
         mon_done++;
         mon_done_cyc      = cyc;
         mon_ready_at_done = ready_a[k];
      end
      if (dout_valid_a[k]) begin
         mon_dv++;
         check("dv_with_done", done_a[k], 1);
         if (exp_q.size() == 0) check("dv_unexpected", dout_valid_a[k], 0);
         else                   check("dout_read", dout_a[k], exp_q.pop_front());
      end
      mon_prev_sclk = sclk_a[k];
      mon_prev_ss   = ss_n_a[k];
   endtask

   task automatic run_txn(input int k, input logic [1:0] c, input logic [7:0] d,
                          input logic [7:0] rx, input bit mid_pulse);
      int   per, act, n, div;
      bit   rd;
      div = div_of(k);
      rd  = (c == CMD_RD_DATA);
      per = rd ? 23 : 13;
      act = per - 2;
      mon_clear(rx);
      if (rd) exp_q.push_back(rx);
      @(negedge clk);
      check("ready_idle", ready_a[k], 1);
      cmd_a[k]   = c;
      din_a[k]   = d;
      start_a[k] = 1'b1;
      mon_step(k);
      start_a[k] = 1'b0;
      check("ss_fall_next_cycle", ss_n_a[k], 0);
      n = 0;
      while (mon_done == 0 && n < 300) begin
         mon_step(k);
         n++;
         if (mid_pulse && n == 20) begin
            start_a[k] = 1'b1;
            cmd_a[k]   = CMD_RD_DATA;
            din_a[k]   = 8'hFF;
         end
         if (mid_pulse && n == 21) start_a[k] = 1'b0;
      end
      if (rd) exp_dout[k] = rx;
      check("done_seen", mon_done, 1);
      check("done_latency", mon_done_cyc - mon_fall_cyc, 2 * div * per);
      check("ss_low_cycles", mon_low, 2 * div * act);
      check("sclk_rises", mon_rises, act);
      check("mosi_frame", {22'd0, mon_bits}, {22'd0, c, d});
      check("ready_at_done", mon_ready_at_done, 0);
      check("dv_count", mon_dv, rd ? 1 : 0);
      check("dout_value", dout_a[k], exp_dout[k]);
      mon_step(k);
      check("ready_after_done", ready_a[k], 1);
      check("done_one_cycle", done_a[k], 0);
      if (mid_pulse) begin
         repeat (10) mon_step(k);
         check("busy_start_ignored", mon_frames, 1);
      end
      check("sclk_low_when_deselected", mon_sclk_bad, 0);
   endtask

   task automatic back_to_back();
      int n;
      bit switched;
      mon_clear(8'h00);
      @(negedge clk);
      cmd_a[0]   = CMD_WR_ADDR;
      din_a[0]   = 8'h11;
      start_a[0] = 1'b1;
      switched   = 1'b0;
      n = 0;
      while (mon_done < 2 && n < 400) begin
         mon_step(0);
         n++;
         if (mon_done == 1 && !switched) begin
            cmd_a[0] = CMD_WR_DATA;
            din_a[0] = 8'h22;
            switched = 1'b1;
         end
         if (mon_frames == 2) start_a[0] = 1'b0;
      end
      start_a[0] = 1'b0;
      check("b2b_done_count", mon_done, 2);
      check("b2b_frames", mon_frames, 2);
      // GAP of 8 cycles + done cycle + ready cycle before the next LEAD
      check("b2b_ss_high_gap", mon_last_hi, 10);
      check("b2b_second_frame", {22'd0, mon_bits}, {22'd0, 2'b01, 8'h22});
      check("b2b_no_dv", mon_dv, 0);
      repeat (20) mon_step(0);
      check("b2b_no_third", mon_frames, 2);
   endtask

   task automatic reset_mid_shift();
      int n;
      mon_clear(8'h00);
      @(negedge clk);
      cmd_a[0]   = CMD_WR_ADDR;
      din_a[0]   = 8'h96;
      start_a[0] = 1'b1;
      mon_step(0);
      start_a[0] = 1'b0;
      n = 0;
      while (mon_rises < 6 && n < 100) begin
         mon_step(0);
         n++;
      end
      check("rst_reached_shift", mon_rises, 6);
      #2 rst = 1'b1;
      #1;
      check("rst_async_ss_n", ss_n_a[0], 1);
      check("rst_async_sclk", sclk_a[0], 0);
      check("rst_async_mosi", mosi_a[0], 0);
      check("rst_async_done", done_a[0], 0);
      check("rst_async_ready", ready_a[0], 1);
      for (int k = 0; k < N; k++) exp_dout[k] = 8'h00;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      mon_done = 0;
      repeat (20) mon_step(0);
      check("rst_no_done", mon_done, 0);
   endtask

   initial begin
      rst = 1'b1;
      for (int k = 0; k < N; k++) begin
         start_a[k]  = 1'b0;
         cmd_a[k]    = 2'b00;
         din_a[k]    = 8'h00;
         miso_a[k]   = 1'b0;
         exp_dout[k] = 8'h00;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < N; k++) begin
         check($sformatf("rst_ready%0d", k), ready_a[k], 1);
         check($sformatf("rst_done%0d", k), done_a[k], 0);
         check($sformatf("rst_dout%0d", k), dout_a[k], 0);
         check($sformatf("rst_dv%0d", k), dout_valid_a[k], 0);
         check($sformatf("rst_sclk%0d", k), sclk_a[k], 0);
         check($sformatf("rst_ss_n%0d", k), ss_n_a[k], 1);
         check($sformatf("rst_mosi%0d", k), mosi_a[k], 0);
         check($sformatf("rst_state%0d", k), st_a[k], ST_IDLE);
      end
      rst = 1'b0;
      mon_clear(8'h00);
      repeat (100) mon_step(0);
      check("idle_sclk_static", mon_rises + mon_falls, 0);
      check("idle_no_frame", mon_frames, 0);

      run_txn(0, CMD_WR_ADDR, 8'hA5, 8'h00, 1'b0);
      run_txn(0, CMD_RD_DATA, 8'h00, 8'h3C, 1'b0);
      run_txn(0, CMD_RD_ADDR, 8'h5A, 8'h00, 1'b1);
      run_txn(0, CMD_WR_DATA, 8'hC3, 8'h00, 1'b0);
      back_to_back();
      reset_mid_shift();
      run_txn(0, CMD_RD_DATA, 8'h00, 8'hA6, 1'b0);
      run_txn(1, CMD_RD_DATA, 8'h00, 8'hFF, 1'b0);
      run_txn(1, CMD_WR_DATA, 8'h5A, 8'h00, 1'b0);
      run_txn(2, CMD_RD_DATA, 8'h00, 8'h01, 1'b0);
      run_txn(2, CMD_WR_ADDR, 8'h3C, 8'h00, 1'b0);
      check("exp_q_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
